// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] ZEROWORD       = '0;
    localparam logic [PC_W-1:0]    DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [PC_W-1:0]    DEF_EXC_VECTOR = 32'h0000_0380;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return a & ~(PC_W'(3));
    endfunction

endpackage

// File: rtl/fetch_ctrl_npc_mux.sv
// Next-PC select: exception > branch > jump > sequential, result word aligned.
module npc_mux
    import fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic            exc_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            redirect_o,
    output logic [PC_W-1:0] npc_o
);

    logic [PC_W-1:0] raw;

    always_comb begin
        raw        = pc_i + PC_W'(4);
        redirect_o = exc_i | branch_taken_i | jump_i;
        if (exc_i) begin
            raw = EXC_VECTOR;
        end else if (branch_taken_i) begin
            raw = branch_target_i;
        end else if (jump_i) begin
            raw = jump_target_i;
        end
        npc_o = word_align(raw);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ack port and
// presents one instruction at a time to IF/ID, with a one-entry skid for stalls.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [PC_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               exc_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic               jump_i,
    input  logic [PC_W-1:0]    jump_target_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               if_valid_o,
    output logic [PC_W-1:0]    if_pc_o,
    output logic [PC_W-1:0]    if_pc4_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output fetch_state_e       state_dbg_o
);

    // Handshake: imem_req_o is a valid that is never withdrawn and whose
    // imem_addr_o is frozen until the cycle imem_ack_i is seen (ack may come
    // in the first req cycle). IF/ID is consumed when if_valid_o & !stall_i.

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic               req_d, valid_d;
    logic [PC_W-1:0]    addr_d, ifpc_d, ifpc4_d;
    logic [INSTR_W-1:0] instr_d;
    logic               redirect;
    logic [PC_W-1:0]    npc;

    npc_mux #(.EXC_VECTOR(EXC_VECTOR)) u_npc_mux (
        .exc_i           (exc_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .pc_i            (pc_q),
        .redirect_o      (redirect),
        .npc_o           (npc)
    );

    assign state_dbg_o = state_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        skid_d  = skid_q;
        req_d   = imem_req_o;
        addr_d  = imem_addr_o;
        valid_d = if_valid_o;
        ifpc_d  = if_pc_o;
        ifpc4_d = if_pc4_o;
        instr_d = if_instr_o;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end

            ST_FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = npc;
                    if (imem_ack_i) begin
                        addr_d = npc;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    if (!stall_i || !if_valid_o) begin
                        instr_d = imem_rdata_i;
                        ifpc_d  = pc_q;
                        ifpc4_d = npc;
                        valid_d = 1'b1;
                        pc_d    = npc;
                        addr_d  = npc;
                    end else begin
                        // Slot still occupied: park the word and pause fetching.
                        skid_d  = imem_rdata_i;
                        req_d   = 1'b0;
                        state_d = ST_HOLD;
                    end
                end else if (if_valid_o && !stall_i) begin
                    valid_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = npc;
                    req_d   = 1'b1;
                    addr_d  = npc;
                    state_d = ST_FETCH;
                end else if (!stall_i) begin
                    instr_d = skid_q;
                    ifpc_d  = pc_q;
                    ifpc4_d = npc;
                    valid_d = 1'b1;
                    pc_d    = npc;
                    req_d   = 1'b1;
                    addr_d  = npc;
                    state_d = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // The outstanding response belongs to a squashed path.
                valid_d = 1'b0;
                if (redirect) begin
                    pc_d = npc;
                end
                if (imem_ack_i) begin
                    addr_d  = redirect ? npc : pc_q;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            skid_q      <= ZEROWORD;
            imem_req_o  <= 1'b0;
            imem_addr_o <= '0;
            if_valid_o  <= 1'b0;
            if_pc_o     <= '0;
            if_pc4_o    <= '0;
            if_instr_o  <= ZEROWORD;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            skid_q      <= skid_d;
            imem_req_o  <= req_d;
            imem_addr_o <= addr_d;
            if_valid_o  <= valid_d;
            if_pc_o     <= ifpc_d;
            if_pc4_o    <= ifpc4_d;
            if_instr_o  <= instr_d;
        end
    end

endmodule
